// File: rtl/sdspi_host_responder.sv
// SD-SPI host-side command responder backed by on-chip block RAM.
// Stands in for an SD-SPI host plus card and reproduces the busy handshake that SD masters rely on.
module sdspi_host_responder #(
   parameter int unsigned NUM_BLOCKS  = 4,
   parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
   parameter int unsigned INIT_CYCLES = 16,
   parameter int unsigned BLOCK_LAT   = 8,
   parameter int unsigned BYTE_LAT    = 2,
   parameter int unsigned COMMIT_LAT  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_rst,
   input  logic [31:0] spi_block_addr,
   input  logic        spi_r_block,
   input  logic        spi_r_byte,
   input  logic        spi_r_multi_block,
   input  logic        spi_w_block,
   input  logic        spi_w_byte,
   input  logic [7:0]  spi_data_in,
   input  logic        inject_crc_err,
   output logic [7:0]  spi_data_out,
   output logic        spi_busy,
   output logic        spi_err,
   output logic        spi_crc_err
);

   localparam int unsigned BLK_BYTES = 512;
   localparam int unsigned PTR_W     = 10;
   localparam int unsigned BLK_W     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
   localparam int unsigned AW        = BLK_W + 9;
   localparam int unsigned DEPTH     = NUM_BLOCKS * BLK_BYTES;
   localparam int unsigned CNT_W     = 16;

   // Last counter value of each busy phase; a zero latency behaves like one cycle.
   localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'((INIT_CYCLES > 0 ? INIT_CYCLES : 1) - 1);
   localparam logic [CNT_W-1:0] FETCH_LAST  = CNT_W'((BLOCK_LAT   > 0 ? BLOCK_LAT   : 1) - 1);
   localparam logic [CNT_W-1:0] BYTE_LAST   = CNT_W'((BYTE_LAT    > 0 ? BYTE_LAT    : 1) - 1);
   localparam logic [CNT_W-1:0] COMMIT_LAST = CNT_W'((COMMIT_LAT  > 0 ? COMMIT_LAT  : 1) - 1);
   localparam logic [PTR_W-1:0] PTR_END     = PTR_W'(BLK_BYTES);

   typedef enum logic [3:0] {
      UNINIT,
      INIT,
      READY,
      RD_FETCH,
      RD_OPEN,
      RD_BYTE,
      WR_OPEN,
      WR_BYTE,
      COMMIT
   } state_t;

   state_t             state_q, state_d;
   logic               busy_q, busy_d;
   logic [7:0]         data_q, data_d;
   logic               err_q, err_d;
   logic               crc_q, crc_d;
   logic [BLK_W-1:0]   blk_q, blk_d;
   logic               rng_q, rng_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [7:0]         mem [DEPTH];
   logic               mem_we_c;
   logic [AW-1:0]      mem_addr_c;
   logic [7:0]         mem_rd_c;

   logic [32:0]        addr_diff_c;
   logic               cmd_rng_err_c;
   logic [BLK_W-1:0]   cmd_blk_c;
   logic               rd_req_c;
   logic               ptr_in_blk_c;
   logic [PTR_W-1:0]   ptr_inc_c;
   logic [CNT_W-1:0]   cnt_inc_c;

   // Block address decode: underflow below BASE_ADDR or beyond the stored blocks is a range error.
   assign addr_diff_c   = {1'b0, spi_block_addr} - {1'b0, BASE_ADDR};
   assign cmd_rng_err_c = addr_diff_c[32] || (addr_diff_c[31:0] >= 32'(NUM_BLOCKS));
   assign cmd_blk_c     = addr_diff_c[BLK_W-1:0];

   assign rd_req_c      = spi_r_block | spi_r_multi_block;
   assign ptr_in_blk_c  = (ptr_q < PTR_END);
   assign ptr_inc_c     = ptr_in_blk_c ? ptr_q + PTR_W'(1) : ptr_q;
   assign cnt_inc_c     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
   assign mem_addr_c    = {blk_q, ptr_q[8:0]};
   assign mem_rd_c      = (ptr_in_blk_c && !rng_q) ? mem[mem_addr_c] : 8'hFF;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= UNINIT;
         busy_q  <= 1'b0;
         data_q  <= 8'hFF;
         err_q   <= 1'b0;
         crc_q   <= 1'b0;
         blk_q   <= '0;
         rng_q   <= 1'b0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         data_q  <= data_d;
         err_q   <= err_d;
         crc_q   <= crc_d;
         blk_q   <= blk_d;
         rng_q   <= rng_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Block storage survives rst; only committed-in-place byte writes change it.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem[mem_addr_c] <= spi_data_in;
      end
   end

   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      data_d   = data_q;
      err_d    = err_q;
      crc_d    = crc_q;
      blk_d    = blk_q;
      rng_d    = rng_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      mem_we_c = 1'b0;

      if (spi_rst && (state_q != INIT)) begin
         // Soft init aborts any open session without committing.
         state_d = INIT;
         busy_d  = 1'b1;
         cnt_d   = '0;
         err_d   = 1'b0;
         crc_d   = 1'b0;
      end else begin
         unique case (state_q)
            UNINIT: begin
               if (rd_req_c || spi_w_block) begin
                  err_d = 1'b1;
               end
            end
            INIT: begin
               if ((cnt_q >= INIT_LAST) && !spi_rst) begin
                  state_d = READY;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_inc_c;
               end
            end
            READY: begin
               if (rd_req_c || spi_w_block) begin
                  blk_d = cmd_blk_c;
                  rng_d = cmd_rng_err_c;
                  ptr_d = '0;
                  if (cmd_rng_err_c) begin
                     err_d = 1'b1;
                  end
                  if (rd_req_c) begin
                     crc_d   = inject_crc_err;
                     state_d = RD_FETCH;
                     busy_d  = 1'b1;
                     cnt_d   = '0;
                  end else begin
                     state_d = WR_OPEN;
                  end
               end
            end
            RD_FETCH: begin
               if (cnt_q >= FETCH_LAST) begin
                  state_d = RD_OPEN;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_inc_c;
               end
            end
            RD_OPEN: begin
               if (spi_r_byte) begin
                  data_d  = mem_rd_c;
                  ptr_d   = ptr_inc_c;
                  state_d = RD_BYTE;
                  busy_d  = 1'b1;
                  cnt_d   = '0;
               end else if (!rd_req_c) begin
                  state_d = READY;
               end
            end
            RD_BYTE: begin
               if ((cnt_q >= BYTE_LAST) && !spi_r_byte) begin
                  state_d = RD_OPEN;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_inc_c;
               end
            end
            WR_OPEN: begin
               if (spi_w_byte) begin
                  mem_we_c = ptr_in_blk_c && !rng_q;
                  ptr_d    = ptr_inc_c;
                  state_d  = WR_BYTE;
                  busy_d   = 1'b1;
                  cnt_d    = '0;
               end else if (!spi_w_block) begin
                  state_d = COMMIT;
                  busy_d  = 1'b1;
                  cnt_d   = '0;
               end
            end
            WR_BYTE: begin
               if ((cnt_q >= BYTE_LAST) && !spi_w_byte) begin
                  state_d = WR_OPEN;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_inc_c;
               end
            end
            COMMIT: begin
               if (cnt_q >= COMMIT_LAST) begin
                  state_d = READY;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_inc_c;
               end
            end
            default: begin
               state_d = UNINIT;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   assign spi_data_out = data_q;
   assign spi_busy     = busy_q;
   assign spi_err      = err_q;
   assign spi_crc_err  = crc_q;

endmodule

// File: tb/tb_sdspi_host_responder.sv
// Scoreboard bench for sdspi_host_responder: expected read bytes are queued when a
// read is requested and compared when busy falls.
module tb_sdspi_host_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        spi_rst;
   logic [31:0] spi_block_addr;
   logic        spi_r_block;
   logic        spi_r_byte;
   logic        spi_r_multi_block;
   logic        spi_w_block;
   logic        spi_w_byte;
   logic [7:0]  spi_data_in;
   logic        inject_crc_err;
   logic [7:0]  spi_data_out;
   logic        spi_busy;
   logic        spi_err;
   logic        spi_crc_err;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   sdspi_host_responder dut (
      .clk               (clk),
      .rst               (rst),
      .spi_rst           (spi_rst),
      .spi_block_addr    (spi_block_addr),
      .spi_r_block       (spi_r_block),
      .spi_r_byte        (spi_r_byte),
      .spi_r_multi_block (spi_r_multi_block),
      .spi_w_block       (spi_w_block),
      .spi_w_byte        (spi_w_byte),
      .spi_data_in       (spi_data_in),
      .inject_crc_err    (inject_crc_err),
      .spi_data_out      (spi_data_out),
      .spi_busy          (spi_busy),
      .spi_err           (spi_err),
      .spi_crc_err       (spi_crc_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Waits (bounded) for spi_busy to reach lvl, sampling on falling edges.
   task automatic wait_level(input logic lvl, input string tag);
      int n = 0;
      while ((spi_busy !== lvl) && (n < 1000)) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(spi_busy), 32'(lvl));
   endtask

   // Measures the length of the next busy pulse.
   task automatic measure_busy(input string tag, input int exp_len);
      int n = 1;
      wait_level(1'b1, {tag, "_rise"});
      while (n < 1000) begin
         @(negedge clk);
         if (spi_busy === 1'b1) n++;
         else break;
      end
      chk({tag, "_len"}, 32'(n), 32'(exp_len));
   endtask

   task automatic do_init();
      int n = 1;
      spi_rst = 1'b1;
      wait_level(1'b1, "init_rise");
      spi_rst = 1'b0;
      while (n < 1000) begin
         @(negedge clk);
         if (spi_busy === 1'b1) n++;
         else break;
      end
      chk("init_len", 32'(n), 32'd16);
      chk("init_err", 32'(spi_err), 32'd0);
      chk("init_crc", 32'(spi_crc_err), 32'd0);
   endtask

   task automatic wr_byte(input logic [7:0] d);
      spi_w_byte  = 1'b1;
      spi_data_in = d;
      wait_level(1'b1, "wbyte_rise");
      spi_w_byte = 1'b0;
      wait_level(1'b0, "wbyte_fall");
   endtask

   task automatic rd_byte(input string tag, input int hold);
      logic [7:0] e;
      spi_r_byte = 1'b1;
      wait_level(1'b1, {tag, "_rise"});
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         chk({tag, "_held_busy"}, 32'(spi_busy), 32'd1);
      end
      spi_r_byte = 1'b0;
      wait_level(1'b0, {tag, "_fall"});
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk(tag, 32'(spi_data_out), 32'(e));
      end
   endtask

   task automatic open_write(input logic [31:0] addr);
      spi_block_addr = addr;
      spi_w_block    = 1'b1;
      @(negedge clk);
   endtask

   task automatic close_write();
      spi_w_block = 1'b0;
      measure_busy("commit", 8);
   endtask

   task automatic open_read(input logic [31:0] addr, input logic inj, input logic exp_crc);
      spi_block_addr = addr;
      inject_crc_err = inj;
      spi_r_block    = 1'b1;
      @(negedge clk);
      inject_crc_err = 1'b0;
      chk("fetch_crc_entry", 32'(spi_crc_err), 32'(exp_crc));
      measure_busy("fetch", 8);
      chk("fetch_crc", 32'(spi_crc_err), 32'(exp_crc));
   endtask

   task automatic close_read();
      spi_r_block = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; spi_rst = 1'b0; spi_block_addr = '0; spi_r_block = 1'b0;
      spi_r_byte = 1'b0; spi_r_multi_block = 1'b0; spi_w_block = 1'b0;
      spi_w_byte = 1'b0; spi_data_in = '0; inject_crc_err = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 32'(spi_busy), 32'd0);
      chk("rst_data", 32'(spi_data_out), 32'hFF);
      chk("rst_err",  32'(spi_err), 32'd0);
      chk("rst_crc",  32'(spi_crc_err), 32'd0);

      // Block command before init is a sequence error
      spi_r_block = 1'b1;
      @(negedge clk);
      spi_r_block = 1'b0;
      chk("uninit_err", 32'(spi_err), 32'd1);
      chk("uninit_busy", 32'(spi_busy), 32'd0);
      @(negedge clk);
      do_init();

      // Four-byte write to block 1, then read back with a long-held first request
      open_write(32'h0010_0001);
      wr_byte(8'hAA); wr_byte(8'hBB); wr_byte(8'hCC); wr_byte(8'hDD);
      close_write();
      open_read(32'h0010_0001, 1'b0, 1'b0);
      exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
      exp_q.push_back(8'hCC); exp_q.push_back(8'hDD);
      rd_byte("b1_byte0", 10);
      for (int i = 1; i < 4; i++) rd_byte("b1_byte", 0);
      close_read();

      // Partial rewrite keeps the untouched bytes
      open_write(32'h0010_0001);
      wr_byte(8'h11);
      close_write();
      open_read(32'h0010_0001, 1'b0, 1'b0);
      exp_q.push_back(8'h11); exp_q.push_back(8'hBB);
      rd_byte("part_byte0", 0);
      rd_byte("part_byte1", 0);
      close_read();

      // Full block 0 of 0x5A, read one byte past the end
      open_write(32'h0010_0000);
      for (int i = 0; i < 512; i++) wr_byte(8'h5A);
      close_write();
      spi_r_multi_block = 1'b1;
      open_read(32'h0010_0000, 1'b0, 1'b0);
      spi_r_block = 1'b0;
      for (int i = 0; i < 512; i++) exp_q.push_back(8'h5A);
      exp_q.push_back(8'hFF);
      for (int i = 0; i < 513; i++) rd_byte("b0_byte", 0);
      chk("b0_err", 32'(spi_err), 32'd0);
      spi_r_multi_block = 1'b0;
      @(negedge clk);

      // Below BASE_ADDR and past the last block
      open_read(32'h000F_FFFF, 1'b0, 1'b0);
      chk("under_err", 32'(spi_err), 32'd1);
      exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
      rd_byte("under_byte", 0); rd_byte("under_byte", 0);
      close_read();
      do_init();
      open_read(32'h0010_0004, 1'b0, 1'b0);
      chk("over_err", 32'(spi_err), 32'd1);
      exp_q.push_back(8'hFF);
      rd_byte("over_byte", 0);
      close_read();
      do_init();

      // CRC injection, clean follow-up, then soft init during a byte
      open_read(32'h0010_0001, 1'b1, 1'b1);
      exp_q.push_back(8'h11);
      rd_byte("crc_byte", 0);
      chk("crc_held", 32'(spi_crc_err), 32'd1);
      close_read();
      open_read(32'h0010_0001, 1'b0, 1'b0);
      close_read();
      open_read(32'h0010_0001, 1'b1, 1'b1);
      spi_r_byte = 1'b1;
      wait_level(1'b1, "abort_rise");
      spi_rst = 1'b1; spi_r_byte = 1'b0; spi_r_block = 1'b0;
      @(negedge clk);
      spi_rst = 1'b0;
      chk("abort_crc", 32'(spi_crc_err), 32'd0);
      wait_level(1'b0, "abort_fall");
      repeat (5) begin
         @(negedge clk);
         chk("abort_idle_busy", 32'(spi_busy), 32'd0);
      end
      chk("abort_err", 32'(spi_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
